// File: rtl/bit_divider_pkg.sv
// Shared types and constants for the sequential signed restoring divider.
package bit_divider_pkg;

    localparam int unsigned ITER = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        FIX,
        DONE
    } state_t;

    // Active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bit_divider_8_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module div_step
    import bit_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH:0] rq_i,
    input  logic [WIDTH:0]   d_i,
    output logic [2*WIDTH:0] rq_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = rq_i << 1;
        // Extra top bit of the difference acts as the borrow flag
        diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {1'b0, d_i};
        rq_o    = shifted;
        if (!diff[WIDTH+1]) begin
            rq_o[2*WIDTH:WIDTH] = diff[WIDTH:0];
            rq_o[0]             = 1'b1;
        end
    end

endmodule

// File: rtl/bit_divider_8.sv
// Sequential signed restoring divider: FSM, operand/result registers, sign fix-up, hex display.
module bit_divider_8
    import bit_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearR_LoadD,
    input  logic             Run,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Busy,
    output logic             DivZero,
    output logic             Ovf,
    output logic [6:0]       Qhex0,
    output logic [6:0]       Qhex1,
    output logic [6:0]       Rhex0,
    output logic [6:0]       Rhex1
);

    localparam int unsigned      CW       = $clog2(ITER);
    localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t            state_q;
    logic [WIDTH-1:0]  dividend_q;
    logic [WIDTH-1:0]  divisor_q;
    logic [2*WIDTH:0]  rq_q;
    logic [2*WIDTH:0]  rq_d;
    logic [WIDTH:0]    dw_q;
    logic [CW-1:0]     cnt_q;
    logic              negq_q;
    logic              negr_q;
    logic [WIDTH-1:0]  qval_q;
    logic [WIDTH-1:0]  rval_q;
    logic              busy_q;
    logic              dz_q;
    logic              ovf_q;

    logic [WIDTH:0]    mag_dividend;
    logic [WIDTH:0]    mag_divisor;

    // Magnitude in WIDTH+1 bits so the most negative value maps to 2^(WIDTH-1)
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? ('0 - ext) : ext;
    endfunction

    always_comb begin
        mag_dividend = magnitude(dividend_q);
        mag_divisor  = magnitude(divisor_q);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rq_i (rq_q),
        .d_i  (dw_q),
        .rq_o (rq_d)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rq_q       <= '0;
            dw_q       <= '0;
            cnt_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            qval_q     <= '0;
            rval_q     <= '0;
            busy_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ClearR_LoadD) begin
                        dividend_q <= S;
                        qval_q     <= S;
                        rval_q     <= '0;
                    end else if (Run) begin
                        divisor_q <= S;
                        dz_q      <= 1'b0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    rq_q    <= {{(WIDTH+1){1'b0}}, mag_dividend[WIDTH-1:0]};
                    dw_q    <= mag_divisor;
                    negq_q  <= dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
                    negr_q  <= dividend_q[WIDTH-1];
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    rq_q  <= rq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (divisor_q == '0) begin
                        qval_q <= '1;
                        rval_q <= dividend_q;
                        dz_q   <= 1'b1;
                    end else if (dividend_q == MOST_NEG && divisor_q == '1) begin
                        qval_q <= MOST_NEG;
                        rval_q <= '0;
                        ovf_q  <= 1'b1;
                    end else begin
                        qval_q <= negq_q ? -rq_q[WIDTH-1:0] : rq_q[WIDTH-1:0];
                        rval_q <= negr_q ? -rq_q[2*WIDTH-1:WIDTH] : rq_q[2*WIDTH-1:WIDTH];
                    end
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!Run) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Qval    = qval_q;
    assign Rval    = rval_q;
    assign Busy    = busy_q;
    assign DivZero = dz_q;
    assign Ovf     = ovf_q;

    assign Qhex0 = hex_seg(qval_q[3:0]);
    assign Qhex1 = hex_seg(qval_q[WIDTH-1 -: 4]);
    assign Rhex0 = hex_seg(rval_q[3:0]);
    assign Rhex1 = hex_seg(rval_q[WIDTH-1 -: 4]);

endmodule
